// File: rtl/srp16_boot_loader.sv
// ---------------------------------------------------------------------------
// srp16_boot_loader
//
// Byte-stream program loader for the SRP16 core. Accepts a framed image over
// a valid/ready byte interface and writes it word-by-word into processor
// memory. The core is held in reset until the complete image has been
// received and its XOR checksum verified.
//
// Frame (little-endian): ADDR_LO ADDR_HI CNT_LO CNT_HI {LO HI}*CNT CSUM
// CSUM is the XOR of every preceding byte in the frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rx_data    incoming byte
//   rx_valid   rx_data valid
//   rx_ready   loader can accept a byte (from state only)
//   mem_addr   word address of the current write (registered)
//   mem_wdata  word to write (registered)
//   mem_we     one-cycle write strobe (registered)
//   cpu_reset  high until a verified image is loaded
//   load_done  image loaded and checksum matched
//   load_error checksum mismatch
// ---------------------------------------------------------------------------
module srp16_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [3:0] {
        S_ADDR_LO,
        S_ADDR_HI,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_next;

    // lo_byte holds whichever low byte (address, count or data) was last seen;
    // the three uses never overlap in time.
    logic [7:0]            lo_byte;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           count;
    logic [7:0]            checksum;
    logic                  accept;

    assign accept = rx_valid && rx_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ADDR_LO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and rx_ready; every non-terminal state accepts a byte, so
    // acceptance reduces to rx_valid inside those branches.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        case (state)
            S_ADDR_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = S_ADDR_HI;
            end
            S_ADDR_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({rx_data, lo_byte} == 16'h0000) state_next = S_CSUM;
                    else                                state_next = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = S_DATA_HI;
            end
            S_DATA_HI: begin
                rx_ready = 1'b1;
                // count still holds the pre-decrement value here
                if (rx_valid) begin
                    if (count == 16'd1) state_next = S_CSUM;
                    else                state_next = S_DATA_LO;
                end
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data == checksum) state_next = S_DONE;
                    else                     state_next = S_ERROR;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ADDR_LO;
        endcase
    end

    // Datapath: field assembly, running checksum and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_byte   <= '0;
            wr_addr   <= '0;
            count     <= '0;
            checksum  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                checksum <= checksum ^ rx_data;
                case (state)
                    S_ADDR_LO, S_CNT_LO, S_DATA_LO: begin
                        lo_byte <= rx_data;
                    end
                    S_ADDR_HI: begin
                        wr_addr <= ADDR_WIDTH'({rx_data, lo_byte});
                    end
                    S_CNT_HI: begin
                        count <= {rx_data, lo_byte};
                    end
                    S_DATA_HI: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= {rx_data, lo_byte};
                        wr_addr   <= wr_addr + ADDR_WIDTH'(1);
                        count     <= count - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status outputs follow the terminal states directly
    always_comb begin
        cpu_reset  = (state != S_DONE);
        load_done  = (state == S_DONE);
        load_error = (state == S_ERROR);
    end

endmodule

// File: tb/tb_srp16_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_srp16_boot_loader
//
// Self-checking bench for srp16_boot_loader. Directed frames come from a
// vector table; random frames are generated and checked against a frame-level
// reference model (field parsing with plain arithmetic, expected writes held
// in queues). A hand-written sequence covers reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_srp16_boot_loader;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_we;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;

    srp16_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Captured writes
    logic [AW-1:0] got_addr[$];
    logic [15:0]   got_data[$];
    logic          prev_we = 1'b0;

    // Reference model state
    logic [7:0]    frame[$];
    logic [15:0]   words[$];
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    bit            exp_done;

    typedef struct {
        logic [15:0] addr;
        int unsigned cnt;
        logic [15:0] w[4];
        bit          bad;
        int unsigned gap;
        bit          done;
        int unsigned nwr;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge; the strobe must never be
    // high on two consecutive cycles.
    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_width: got 2 consecutive cycles expected 1");
            end
        end
        prev_we = mem_we;
    end

    task automatic build_frame(input logic [15:0] addr, input logic [15:0] cnt, input bit bad);
        logic [7:0] cs;
        frame.delete();
        frame.push_back(addr[7:0]);
        frame.push_back(addr[15:8]);
        frame.push_back(cnt[7:0]);
        frame.push_back(cnt[15:8]);
        for (int i = 0; i < int'(cnt); i++) begin
            frame.push_back(words[i][7:0]);
            frame.push_back(words[i][15:8]);
        end
        cs = 8'h00;
        foreach (frame[i]) cs = cs ^ frame[i];
        frame.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    // Frame-level reference: word i lands at (base + i) mod 2^AW, and the
    // load succeeds when the last byte equals the XOR of all others.
    task automatic model_frame();
        int unsigned base;
        int unsigned n;
        logic [7:0]  x;
        exp_addr.delete();
        exp_data.delete();
        base = 32'({frame[1], frame[0]});
        n    = 32'({frame[3], frame[2]});
        for (int unsigned i = 0; i < n; i++) begin
            exp_addr.push_back(AW'(base + i));
            exp_data.push_back({frame[5 + 2*i], frame[4 + 2*i]});
        end
        x = 8'h00;
        for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
        exp_done = (frame[frame.size() - 1] == x);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, 32'({rx_ready, mem_we, cpu_reset, load_done, load_error}), 32'b10100);
        check({tag, "_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    // Reset with a byte offered at the same edge: reset must win.
    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        @(posedge clk); #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        while (!rx_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic run_frame(input string name, input int unsigned gap,
                             input bit done, input int unsigned nwr);
        int unsigned n;
        n = 32'({frame[3], frame[2]});
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0 && gap > 0) begin
                repeat ($urandom_range(gap, 1)) begin
                    @(posedge clk); #1;
                end
            end
            send_byte(frame[i]);
            if (i >= 5 && i < int'(4 + 2*n) && ((i - 4) % 2) == 1)
                check({name, "_we_latency"}, 32'(mem_we), 32'h1);
        end
        check({name, "_done"}, 32'(load_done), 32'(done));
        check({name, "_error"}, 32'(load_error), 32'(!done));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!done));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check({name, "_nwrites"}, 32'(got_addr.size()), nwr);
        if (got_addr.size() == exp_addr.size()) begin
            foreach (exp_addr[j]) begin
                check($sformatf("%s_addr%0d", name, j), 32'(got_addr[j]), 32'(exp_addr[j]));
                check($sformatf("%s_data%0d", name, j), 32'(got_data[j]), 32'(exp_data[j]));
            end
        end
        check({name, "_ready_end"}, 32'(rx_ready), 32'h0);
        check({name, "_done_hold"}, 32'({load_done, load_error, cpu_reset}),
              32'({done, !done, !done}));
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("power_on");

        // addr, cnt, words, bad csum, gap, expected done, expected writes
        tbl[0] = '{16'h0010, 3, '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000}, 1'b0, 0, 1'b1, 3};
        tbl[1] = '{16'h0010, 3, '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000}, 1'b1, 0, 1'b0, 3};
        tbl[2] = '{16'h0100, 0, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 0, 1'b1, 0};
        tbl[3] = '{16'hFFFF, 2, '{16'h0001, 16'h0002, 16'h0000, 16'h0000}, 1'b0, 0, 1'b1, 2};
        tbl[4] = '{16'h0010, 3, '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000}, 1'b0, 3, 1'b1, 3};

        foreach (tbl[v]) begin
            words.delete();
            for (int k = 0; k < 4; k++) words.push_back(tbl[v].w[k]);
            build_frame(tbl[v].addr, 16'(tbl[v].cnt), tbl[v].bad);
            model_frame();
            do_reset();
            run_frame($sformatf("vec%0d", v), tbl[v].gap, tbl[v].done, tbl[v].nwr);
        end

        // Reset after six bytes of the normal frame, then a fresh frame
        words.delete();
        words.push_back(16'h1234);
        words.push_back(16'h5678);
        words.push_back(16'h9ABC);
        build_frame(16'h0010, 16'd3, 1'b0);
        do_reset();
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        @(posedge clk); #1;
        check("midrst_pre_nwr", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() == 1) begin
            check("midrst_pre_addr", 32'(got_addr[0]), 32'h0010);
            check("midrst_pre_data", 32'(got_data[0]), 32'h1234);
        end
        do_reset();
        words.delete();
        words.push_back(16'hBEEF);
        build_frame(16'h0200, 16'd1, 1'b0);
        model_frame();
        run_frame("midrst_new", 0, 1'b1, 1);

        // Randomized frames against the reference model
        for (int r = 0; r < 25; r++) begin
            logic [15:0] a;
            int unsigned c;
            a = 16'($urandom);
            if ($urandom_range(3) == 0) a = 16'hFFFF - 16'($urandom_range(3));
            c = $urandom_range(6);
            words.delete();
            for (int k = 0; k < int'(c); k++) words.push_back(16'($urandom));
            build_frame(a, 16'(c), ($urandom_range(3) == 0));
            model_frame();
            do_reset();
            run_frame($sformatf("rand%0d", r), $urandom_range(2), exp_done, exp_addr.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
